// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised line, mid-bit sampling,
// optional even/odd parity, 1 or 2 stop bits, and a one-word holding register
// with a valid/ready handshake and an overrun pulse when a frame is dropped.
module uart_rx_param #(
    parameter int clksPerBit = 234,
    parameter int dataBits   = 8,
    parameter int parityMode = 1,
    parameter int stopBits   = 1
) (
    input  logic                i_clkRx,
    input  logic                i_rstRxN,
    input  logic                i_rxBit,
    input  logic                i_rxReady,
    output logic                o_rxValid,
    output logic [dataBits-1:0] o_rxBits,
    output logic                o_parityError,
    output logic                o_frameError,
    output logic                o_overrun,
    output logic                o_busy
);

    localparam int CNT_W = (clksPerBit > 1) ? $clog2(clksPerBit) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(clksPerBit / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(clksPerBit - 1);
    localparam logic [3:0]       DATA_LAST = 4'(dataBits - 1);
    localparam logic [3:0]       STOP_LAST = 4'(stopBits - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [dataBits-1:0] shift_q, shift_d;
    logic                perr_q, perr_d, ferr_q, ferr_d;
    logic                armed_q, armed_d;
    logic                pend_q, pend_d;
    logic                valid_q, valid_d;
    logic [dataBits-1:0] bits_q, bits_d;
    logic                oper_q, oper_d, ofer_q, ofer_d, ovr_q, ovr_d;
    logic                rx_s;

    // Parity check of the received word against the sampled parity bit.
    function automatic logic parity_fail(input logic [dataBits-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        case (parityMode)
            1:       return x;
            2:       return ~x;
            default: return 1'b0;
        endcase
    endfunction

    assign rx_s = sync2_q;

    // Next-state logic: synchroniser, frame FSM, and output holding register.
    always_comb begin
        sync1_d = i_rxBit;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        // The line must be seen high before a new start bit is accepted (break recovery).
        armed_d = armed_q | rx_s;
        pend_d  = 1'b0;
        valid_d = valid_q;
        bits_d  = bits_q;
        oper_d  = oper_q;
        ofer_d  = ofer_q;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s && armed_q) begin
                    state_d = S_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[dataBits-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (parityMode != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = parity_fail(shift_q, rx_s);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        pend_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A finished frame is committed one cycle after its last stop sample.
        if (pend_q) begin
            if (!valid_q || i_rxReady) begin
                valid_d = 1'b1;
                bits_d  = shift_q;
                oper_d  = perr_q;
                ofer_d  = ferr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_rxReady) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clkRx or negedge i_rstRxN) begin
        if (!i_rstRxN) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            bits_q  <= '0;
            oper_q  <= 1'b0;
            ofer_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            bits_q  <= bits_d;
            oper_q  <= oper_d;
            ofer_q  <= ofer_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_rxValid     = valid_q;
    assign o_rxBits      = bits_q;
    assign o_parityError = oper_q;
    assign o_frameError  = ofer_q;
    assign o_overrun     = ovr_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule
